// File: rtl/divu_restoring_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : divu_restoring_seq                                         |
// | Description : Iterative unsigned restoring divider, one quotient bit per |
// |               clock. Operands enter through a valid/ready handshake and  |
// |               the quotient/remainder leave through a second one.         |
// | Parameters  : WIDTH - operand/result width in bits (2..32)               |
// | Ports       : clk, rst (async, active-high)                              |
// |               in_valid/in_ready, dividend, divisor   - operation input   |
// |               out_valid/out_ready, quotient,                             |
// |               remainder, div_by_zero                 - result output     |
// |               busy                                   - not idle          |
// | Build macro : DIVU_DIVZERO_FAST_EN - a zero divisor skips the iteration  |
// |               loop and produces its result one edge after accept.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module divu_restoring_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);

   localparam int         CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

`ifdef DIVU_DIVZERO_FAST_EN
   localparam bit C_FAST_DZ = 1'b1;
`else
   localparam bit C_FAST_DZ = 1'b0;
`endif

   logic [1:0]       state_q,       state_d;
   logic [WIDTH:0]   acc_q,         acc_d;
   logic [WIDTH-1:0] q_q,           q_d;
   logic [WIDTH-1:0] d_q,           d_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic             dz_q,          dz_d;
   logic [WIDTH-1:0] quotient_q,    quotient_d;
   logic [WIDTH-1:0] remainder_q,   remainder_d;
   logic             div_by_zero_q, div_by_zero_d;
   logic             out_valid_q,   out_valid_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Partial remainder shifted left by one with the next dividend bit, and
   // the trial subtraction; trial[WIDTH] set means the subtraction borrowed.
   assign shifted = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, d_q};

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      q_d           = q_q;
      d_d           = d_q;
      cnt_d         = cnt_q;
      dz_d          = dz_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;
      out_valid_d   = out_valid_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               acc_d   = '0;
               q_d     = dividend;
               d_d     = divisor;
               cnt_d   = '0;
               dz_d    = (divisor == '0);
               state_d = S_CALC;
               // Fast path preloads exactly what the full loop would have
               // produced for a zero divisor: all-ones quotient, remainder
               // equal to the dividend.
               if (C_FAST_DZ && (divisor == '0)) begin
                  acc_d   = {1'b0, dividend};
                  q_d     = '1;
                  state_d = S_DONE;
               end
            end
         end
         S_CALC: begin
            if (!trial[WIDTH]) begin
               acc_d = trial;
               q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = shifted;
               q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // First DONE cycle registers the result; it is then held
            // unchanged for as long as the consumer stalls.
            if (!out_valid_q) begin
               out_valid_d   = 1'b1;
               quotient_d    = q_q;
               remainder_d   = acc_q[WIDTH-1:0];
               div_by_zero_d = dz_q;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         acc_q         <= '0;
         q_q           <= '0;
         d_q           <= '0;
         cnt_q         <= '0;
         dz_q          <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         q_q           <= q_d;
         d_q           <= d_d;
         cnt_q         <= cnt_d;
         dz_q          <= dz_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_divu_restoring_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_divu_restoring_seq                                      |
// | Description : Self-checking bench for divu_restoring_seq (WIDTH=4 with a |
// |               result scoreboard, plus a WIDTH=8 instance).               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_divu_restoring_seq;

`ifdef DIVU_DIVZERO_FAST_EN
   localparam int DZ_LAT = 1;
`else
   localparam int DZ_LAT = 5;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] dividend = '0;
   logic [3:0] divisor  = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;
   logic       busy;

   logic       in_valid8 = 1'b0;
   logic       in_ready8;
   logic [7:0] dividend8 = '0;
   logic [7:0] divisor8  = '0;
   logic       out_valid8;
   logic       out_ready8 = 1'b1;
   logic [7:0] quotient8;
   logic [7:0] remainder8;
   logic       div_by_zero8;
   logic       busy8;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [3:0] q;
      logic [3:0] r;
      logic       dz;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb[$];
   logic prev_ov = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   divu_restoring_seq #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .busy(busy)
   );

   divu_restoring_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .dividend(dividend8), .divisor(divisor8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .quotient(quotient8), .remainder(remainder8),
      .div_by_zero(div_by_zero8), .busy(busy8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard monitor: latency checked when out_valid rises, values
   // checked and entry retired on the handshake.
   always @(negedge clk) begin
      #1;
      if (out_valid && !prev_ov) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            chk("latency", cyc - sb[0].acc, sb[0].lat);
         end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
         chk("quotient",    {28'd0, quotient},  {28'd0, sb[0].q});
         chk("remainder",   {28'd0, remainder}, {28'd0, sb[0].r});
         chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, sb[0].dz});
         void'(sb.pop_front());
      end
      prev_ov = out_valid;
   end

   task automatic op4(input logic [3:0] n, input logic [3:0] d);
      exp_t e;
      int   k;
      @(negedge clk);
      k = 0;
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      e.q   = (d == 0) ? 4'hF : n / d;
      e.r   = (d == 0) ? n : n % d;
      e.dz  = (d == 0);
      e.lat = (d == 0) ? DZ_LAT : 5;
      e.acc = cyc + 1;
      sb.push_back(e);
      in_valid = 1'b1;
      dividend = n;
      divisor  = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic op8(input logic [7:0] n, input logic [7:0] d,
                      input logic [7:0] eq, input logic [7:0] er);
      int lat;
      @(negedge clk);
      lat = 0;
      while (!in_ready8 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      in_valid8 = 1'b1;
      dividend8 = n;
      divisor8  = d;
      @(negedge clk);
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("w8_latency", lat, 9);
      chk("w8_quotient",  {24'd0, quotient8},  {24'd0, eq});
      chk("w8_remainder", {24'd0, remainder8}, {24'd0, er});
      chk("w8_dz", {31'd0, div_by_zero8}, 32'd0);
   endtask

   initial begin
      int k;
      #1;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_quotient",  {28'd0, quotient},  32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed cases
      op4(4'd13, 4'd3);
      drain();
      op4(4'd9, 4'd0);
      drain();

      // Exhaustive WIDTH=4 sweep
      for (int n = 0; n < 16; n++) begin
         for (int d = 0; d < 16; d++) begin
            op4(n[3:0], d[3:0]);
         end
      end
      drain();

      // Backpressure: result held, no accept while stalled
      out_ready = 1'b0;
      op4(4'd15, 4'd15);
      k = 0;
      while (!out_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("bp_quotient",  {28'd0, quotient},  32'd1);
         chk("bp_remainder", {28'd0, remainder}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
      chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
      drain();

      // Reset in the middle of an operation
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 4'd14;
      divisor  = 4'd4;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_quotient",  {28'd0, quotient},  32'd0);
      chk("abort_remainder", {28'd0, remainder}, 32'd0);
      chk("abort_dz",        {31'd0, div_by_zero}, 32'd0);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
      chk("abort_busy",      {31'd0, busy},      32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      op4(4'd7, 4'd2);
      drain();

      // WIDTH=8 instance
      op8(8'd255, 8'd16, 8'd15, 8'd15);
      op8(8'd0,   8'd5,  8'd0,  8'd0);
      op8(8'd200, 8'd1,  8'd200, 8'd0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
